// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Optional define ALU_PRIO_EN: requester 0 gets strict priority over the rest.
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned FW      = 4,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned IDW     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_A,
    input  logic [NUM_REQ*DW-1:0] req_B,
    input  logic [NUM_REQ*FW-1:0] req_fun,
    output logic [DW-1:0]         alu_A,
    output logic [DW-1:0]         alu_B,
    output logic [FW-1:0]         alu_fun,
    input  logic [DW-1:0]         alu_Y,
    input  logic                  alu_c_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW-1:0]         rsp_Y,
    output logic                  rsp_c_out
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam int unsigned    CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(ALU_LAT - 1);

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] grant;
    logic           found;
    logic           arb_en;
    logic           accept;
    logic           cnt_last;
    int unsigned    cand;

    assign cnt_last = (cnt == CNT_LAST);

    // Search from ptr upward with wrap; first valid requester wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = 0;
`ifdef ALU_PRIO_EN
        if (req_valid[0]) begin
            found = 1'b1;
        end
`endif
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr) + i) % NUM_REQ;
`ifdef ALU_PRIO_EN
            if (!found && (cand != 0) && req_valid[IDW'(cand)]) begin
`else
            if (!found && req_valid[IDW'(cand)]) begin
`endif
                found = 1'b1;
                grant = IDW'(cand);
            end
        end
    end

    always_comb begin
        ptr_nxt = '0;
        if (grant != IDW'(NUM_REQ - 1)) begin
            ptr_nxt = IDW'(grant + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt_last) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = accept ? EXEC : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration is open in IDLE and on the response handshake cycle.
    always_comb begin
        arb_en    = 1'b0;
        req_ready = '0;
        case (state)
            IDLE:    arb_en = 1'b1;
            RESP:    arb_en = rsp_ready;
            default: arb_en = 1'b0;
        endcase
        accept = arb_en && found && rst_n;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            cnt       <= '0;
            alu_A     <= '0;
            alu_B     <= '0;
            alu_fun   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_Y     <= '0;
            rsp_c_out <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    cnt <= CW'(cnt + 1'b1);
                    if (cnt_last) begin
                        rsp_Y     <= alu_Y;
                        rsp_c_out <= alu_c_out;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (accept) begin
                alu_A   <= req_A[grant*DW +: DW];
                alu_B   <= req_B[grant*DW +: DW];
                alu_fun <= req_fun[grant*FW +: FW];
                rsp_id  <= grant;
                cnt     <= '0;
`ifdef ALU_PRIO_EN
                if (grant != '0) begin
                    ptr <= ptr_nxt;
                end
`else
                ptr <= ptr_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural adder ALU.
// Expectations for the ALU_PRIO_EN build are selected by the same define.
module tb_alu_share_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DW      = 32;
    localparam int unsigned FW      = 4;
    localparam int unsigned IDW     = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_A;
    logic [NUM_REQ*DW-1:0] req_B;
    logic [NUM_REQ*FW-1:0] req_fun;
    logic [DW-1:0]         alu_A;
    logic [DW-1:0]         alu_B;
    logic [FW-1:0]         alu_fun;
    logic [DW-1:0]         alu_Y;
    logic                  alu_c_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [DW-1:0]         rsp_Y;
    logic                  rsp_c_out;

    int checks;
    int failures;

    alu_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DW      (DW),
        .FW      (FW),
        .ALU_LAT (1),
        .IDW     (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_A     (req_A),
        .req_B     (req_B),
        .req_fun   (req_fun),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .alu_fun   (alu_fun),
        .alu_Y     (alu_Y),
        .alu_c_out (alu_c_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_Y     (rsp_Y),
        .rsp_c_out (rsp_c_out)
    );

    // fun 0 adds with carry out; any other code XORs.
    always_comb begin
        if (alu_fun == '0) begin
            {alu_c_out, alu_Y} = {1'b0, alu_A} + {1'b0, alu_B};
        end else begin
            {alu_c_out, alu_Y} = {1'b0, alu_A ^ alu_B};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int unsigned k, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [FW-1:0] f);
        req_A[k*DW +: DW]   = a;
        req_B[k*DW +: DW]   = b;
        req_fun[k*FW +: FW] = f;
    endtask

    task automatic do_reset();
        tick();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int unsigned k = 0; k < NUM_REQ; k++) set_lane(k, 32'h55, 32'h66, 4'h3);
        #13;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_Y !== 32'h0 || rsp_c_out !== 1'b0) begin failures++; $display("FAIL reset_rsp_data got=%h/%b exp=0/0", rsp_Y, rsp_c_out); end
        checks++; if (alu_A !== 32'h0 || alu_B !== 32'h0 || alu_fun !== 4'h0) begin failures++; $display("FAIL reset_alu got=%h/%h/%h exp=0/0/0", alu_A, alu_B, alu_fun); end
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || alu_A !== 32'h0) begin failures++; $display("FAIL idle_no_req got=%b/%b/%h exp=0/0000/0", rsp_valid, req_ready, alu_A); end
    endtask

    task automatic test_single();
        set_lane(2, 32'd5, 32'd3, 4'h0);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_req_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin failures++; $display("FAIL single_exec got=%b/%b exp=0000/0", req_ready, rsp_valid); end
        checks++; if (alu_A !== 32'd5 || alu_B !== 32'd3) begin failures++; $display("FAIL single_alu got=%h/%h exp=5/3", alu_A, alu_B); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin failures++; $display("FAIL single_rsp got=%b/%0d exp=1/2", rsp_valid, rsp_id); end
        checks++; if (rsp_Y !== 32'd8 || rsp_c_out !== 1'b0) begin failures++; $display("FAIL single_data got=%h/%b exp=8/0", rsp_Y, rsp_c_out); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_done got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic [IDW-1:0] eid;
        do_reset();
        for (int unsigned k = 0; k < NUM_REQ; k++) set_lane(k, 32'(k * 16 + 1), 32'(k), 4'h0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int unsigned n = 0; n < 6; n++) begin
            eid = IDW'(n % NUM_REQ);
            ea  = 32'(eid * 16 + 1);
            eb  = 32'(eid);
            tick();
            checks++; if (rsp_valid !== 1'b0 || alu_A !== ea) begin failures++; $display("FAIL rr_exec n=%0d got=%b/%h exp=0/%h", n, rsp_valid, alu_A, ea); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_Y !== ea + eb) begin
                failures++; $display("FAIL rr_rsp n=%0d got=%b/%0d/%h exp=1/%0d/%h", n, rsp_valid, rsp_id, rsp_Y, eid, ea + eb);
            end
        end
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_carry_hold();
        set_lane(1, 32'hFFFF_FFFF, 32'd1, 4'h0);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL carry_req_ready got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (alu_A !== 32'hFFFF_FFFF) begin failures++; $display("FAIL carry_alu_A got=%h exp=ffffffff", alu_A); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_Y !== 32'h0 || rsp_c_out !== 1'b1) begin
            failures++; $display("FAIL carry_rsp got=%b/%h/%b exp=1/0/1", rsp_valid, rsp_Y, rsp_c_out);
        end
        tick();
        tick();
        tick();
        checks++; if (alu_A !== 32'hFFFF_FFFF || rsp_valid !== 1'b0) begin failures++; $display("FAIL carry_hold got=%h/%b exp=ffffffff/0", alu_A, rsp_valid); end
        set_lane(3, 32'h0F0F, 32'h00FF, 4'hF);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        checks++; if (alu_fun !== 4'hF || alu_A !== 32'h0F0F) begin failures++; $display("FAIL fun_pass got=%h/%h exp=f/0f0f", alu_fun, alu_A); end
        tick();
        checks++; if (rsp_Y !== 32'h0FF0 || rsp_id !== 2'd3) begin failures++; $display("FAIL fun_rsp got=%h/%0d exp=0ff0/3", rsp_Y, rsp_id); end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_lane(0, 32'd10, 32'd20, 4'h0);
        set_lane(1, 32'd100, 32'd1, 4'h0);
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_Y !== 32'd30) begin
            failures++; $display("FAIL bp_first got=%b/%0d/%h exp=1/0/1e", rsp_valid, rsp_id, rsp_Y);
        end
        for (int unsigned n = 0; n < 5; n++) begin
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_Y !== 32'd30 || req_ready !== 4'b0000) begin
                failures++; $display("FAIL bp_stall n=%0d got=%b/%0d/%h/%b exp=1/0/1e/0000", n, rsp_valid, rsp_id, rsp_Y, req_ready);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_grant got=%b exp=0010", req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd1 || alu_A !== 32'd100) begin
            failures++; $display("FAIL bp_b2b_exec got=%b/%0d/%h exp=0/1/64", rsp_valid, rsp_id, alu_A);
        end
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_Y !== 32'd101) begin failures++; $display("FAIL bp_second got=%b/%h exp=1/65", rsp_valid, rsp_Y); end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        set_lane(1, 32'd7, 32'd7, 4'h0);
        set_lane(2, 32'd9, 32'd9, 4'h0);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || alu_A !== 32'h0 || alu_B !== 32'h0 || req_ready !== 4'b0000) begin
            failures++; $display("FAIL rst_exec got=%b/%h/%h/%b exp=0/0/0/0000", rsp_valid, alu_A, alu_B, req_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_no_replay got=%b exp=0", rsp_valid); end
        req_valid = 4'b0110;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rst_ptr_grant got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_Y !== 32'd14) begin
            failures++; $display("FAIL rst_after_rsp got=%b/%0d/%h exp=1/1/e", rsp_valid, rsp_id, rsp_Y);
        end
        tick();
    endtask

    task automatic test_priority();
        logic [IDW-1:0] exp_ids [3];
`ifdef ALU_PRIO_EN
        exp_ids = '{2'd0, 2'd0, 2'd0};
`else
        exp_ids = '{2'd0, 2'd1, 2'd0};
`endif
        do_reset();
        set_lane(0, 32'd1, 32'd1, 4'h0);
        set_lane(1, 32'd2, 32'd2, 4'h0);
        req_valid = 4'b0011;
        rsp_ready = 1'b1;
        for (int unsigned n = 0; n < 3; n++) begin
            tick();
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_ids[n]) begin
                failures++; $display("FAIL prio_seq n=%0d got=%b/%0d exp=1/%0d", n, rsp_valid, rsp_id, exp_ids[n]);
            end
        end
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_Y !== 32'd4) begin
            failures++; $display("FAIL prio_low got=%b/%0d/%h exp=1/1/4", rsp_valid, rsp_id, rsp_Y);
        end
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_A     = '0;
        req_B     = '0;
        req_fun   = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_carry_hold();
        test_backpressure();
        test_reset_mid_exec();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
